// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer width, pointer type and Gray helpers.
// Helpers work at the package width; narrower pointers zero-extend safely because
// Gray/binary conversion of a value with leading zeros keeps those bits zero.
package fifo_pkg;

    localparam int unsigned ADDR_WIDTH = 9;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/read_ptr_empty.sv
// Read-side pointer and flag controller of the async FIFO (rclk domain).
// Advances the binary/Gray read pointers on accepted reads and derives registered
// empty, almost_empty, occupancy and a sticky underflow from the synchronised wptr_s.
module read_ptr_empty
    import fifo_pkg::*;
#(
    parameter int unsigned Addr_Width      = fifo_pkg::ADDR_WIDTH,  // must be <= ADDR_WIDTH
    parameter int unsigned ALMOST_EMPTY_TH = 4
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic                underflow_clr,
    input  logic [Addr_Width:0] wptr_s,
    output logic                rd_en,
    output logic [Addr_Width:0] rd_addr,
    output logic [Addr_Width:0] rptr,
    output logic                empty,
    output logic                almost_empty,
    output logic [Addr_Width:0] rd_count,
    output logic                underflow
);

    localparam int unsigned PW = Addr_Width + 1;

    logic [Addr_Width:0] rd_addr_next;
    logic [Addr_Width:0] rptr_next;
    logic [Addr_Width:0] wbin_s;
    logic [Addr_Width:0] cnt_next;
    logic                ae_next;

    // Read accepted only while not empty; empty is the registered flag, so a read
    // that drains the last entry blocks the following request.
    assign rd_en        = rinc & ~empty;
    assign rd_addr_next = rd_addr + {{Addr_Width{1'b0}}, rd_en};
    assign rptr_next    = PW'(bin2gray(ptr_t'(rd_addr_next)));
    assign wbin_s       = PW'(gray2bin(ptr_t'(wptr_s)));
    // Modular difference handles wrap; equals 2**Addr_Width when only the MSBs differ.
    assign cnt_next     = wbin_s - rd_addr_next;
    assign ae_next      = (32'(cnt_next) <= ALMOST_EMPTY_TH);

    // Pointer and flag registers; synchronous reset discards everything on the edge.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rd_addr      <= '0;
            rptr         <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            underflow    <= 1'b0;
        end else begin
            rd_addr      <= rd_addr_next;
            rptr         <= rptr_next;
            empty        <= (rptr_next == wptr_s);
            almost_empty <= ae_next;
            rd_count     <= cnt_next;
            // Set has priority over clear.
            if (rinc && empty) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_read_ptr_empty.sv
// Self-checking bench for read_ptr_empty (Addr_Width=3, depth 8, ALMOST_EMPTY_TH=4).
// The reference model tracks read/write totals as integers and derives flags from
// the occupancy count.
module tb_read_ptr_empty;

    localparam int unsigned AW    = 3;
    localparam int          DEPTH = 8;
    localparam int          MOD   = 16;
    localparam int          TH    = 4;

    logic          rclk = 1'b0;
    logic          rrst;
    logic          rinc;
    logic          underflow_clr;
    logic [AW:0]   wptr_s;
    logic          rd_en;
    logic [AW:0]   rd_addr;
    logic [AW:0]   rptr;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   rd_count;
    logic          underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_rd;
    int m_wr;
    int m_cnt;
    bit m_empty;
    bit m_ae;
    bit m_uf;

    read_ptr_empty #(
        .Addr_Width      (AW),
        .ALMOST_EMPTY_TH (TH)
    ) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rinc          (rinc),
        .underflow_clr (underflow_clr),
        .wptr_s        (wptr_s),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rptr          (rptr),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .rd_count      (rd_count),
        .underflow     (underflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [3:0] gray4(input int v);
        int b;
        b = v % MOD;
        return 4'(b ^ (b >> 1));
    endfunction

    function automatic logic [14:0] exp_vec();
        return {4'(m_rd), gray4(m_rd), m_empty, m_ae, 4'(m_cnt), m_uf};
    endfunction

    wire [14:0] dut_vec = {rd_addr, rptr, empty, almost_empty, rd_count, underflow};

    // Applies current inputs for one edge and advances the model accordingly.
    task automatic tick();
        bit acc;
        bit was_empty;
        wptr_s    = gray4(m_wr);
        #1;
        was_empty = m_empty;
        acc       = rinc && !m_empty;
        @(posedge rclk);
        #1;
        if (rrst) begin
            m_rd = 0; m_cnt = 0; m_empty = 1; m_ae = 1; m_uf = 0;
        end else begin
            m_rd    = (m_rd + int'(acc)) % MOD;
            m_cnt   = (m_wr - m_rd + MOD) % MOD;
            m_empty = (m_cnt == 0);
            m_ae    = (m_cnt <= TH);
            if (rinc && was_empty) m_uf = 1;
            else if (underflow_clr) m_uf = 0;
        end
    endtask

    task automatic do_reset();
        rrst = 1; rinc = 0; underflow_clr = 0; m_wr = 0;
        tick();
        rrst = 0;
    endtask

    task automatic test_reset();
        rrst = 1; rinc = 1; underflow_clr = 0; m_wr = 0;
        tick();
        tick();
        checks++;
        if (dut_vec !== 15'b0000_0000_1_1_0000_0) begin
            failures++;
            $display("FAIL reset act=%b exp=%b", dut_vec, 15'b0000_0000_1_1_0000_0);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_model act=%b exp=%b", dut_vec, exp_vec());
        end
        rrst = 0; rinc = 0;
    endtask

    task automatic test_fill_view();
        m_wr = 5; rinc = 0;
        tick();
        checks++;
        if ({empty, almost_empty, rd_count} !== {1'b0, 1'b0, 4'd5}) begin
            failures++;
            $display("FAIL fill_view act=%b/%b/%0d exp=0/0/5", empty, almost_empty, rd_count);
        end
    endtask

    task automatic test_drain();
        logic [3:0] exp_gray [5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
        for (int i = 0; i < 5; i++) begin
            rinc = 1;
            #1;
            checks++;
            if (rd_en !== 1'b1) begin
                failures++;
                $display("FAIL drain_rd_en[%0d] act=%b exp=1", i, rd_en);
            end
            tick();
            checks++;
            if ({rd_addr, rptr} !== {4'(i + 1), exp_gray[i]}) begin
                failures++;
                $display("FAIL drain_ptr[%0d] act=%h/%b exp=%h/%b", i, rd_addr, rptr,
                         4'(i + 1), exp_gray[i]);
            end
            checks++;
            if ({almost_empty, empty} !== {1'b1, (i == 4)}) begin
                failures++;
                $display("FAIL drain_flags[%0d] act=%b%b exp=1%b", i, almost_empty, empty,
                         (i == 4));
            end
        end
        rinc = 0;
    endtask

    task automatic test_underflow();
        rinc = 1; underflow_clr = 0;
        #1;
        checks++;
        if (rd_en !== 1'b0) begin
            failures++;
            $display("FAIL uf_rd_en act=%b exp=0", rd_en);
        end
        tick();
        checks++;
        if ({rd_addr, underflow} !== {4'd5, 1'b1}) begin
            failures++;
            $display("FAIL uf_set act=%h/%b exp=5/1", rd_addr, underflow);
        end
        rinc = 0;
        tick();
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL uf_hold act=%b exp=1", underflow);
        end
        rinc = 1; underflow_clr = 1;
        tick();
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL uf_set_wins act=%b exp=1", underflow);
        end
        rinc = 0;
        tick();
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL uf_clr act=%b exp=0", underflow);
        end
        underflow_clr = 0;
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL uf_model act=%b exp=%b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_wrap();
        bit saw_wrap = 0;
        m_wr = (m_wr + 1) % MOD; rinc = 0;
        tick();
        for (int i = 0; i < 20; i++) begin
            logic [3:0] prev_rptr;
            prev_rptr = rptr;
            m_wr = (m_wr + 1) % MOD; rinc = 1;
            tick();
            checks++;
            if (dut_vec !== exp_vec() || empty !== 1'b0) begin
                failures++;
                $display("FAIL wrap[%0d] act=%b exp=%b", i, dut_vec, exp_vec());
            end
            if (m_rd == 0) begin
                saw_wrap = 1;
                checks++;
                if ({prev_rptr, rptr} !== 8'b1000_0000) begin
                    failures++;
                    $display("FAIL wrap_gray act=%b->%b exp=1000->0000", prev_rptr, rptr);
                end
            end
        end
        rinc = 0;
        checks++;
        if (!saw_wrap) begin
            failures++;
            $display("FAIL wrap_seen act=0 exp=1");
        end
    endtask

    task automatic test_full_count();
        do_reset();
        m_wr = DEPTH;
        tick();
        checks++;
        if ({wptr_s, rptr, rd_count, empty, almost_empty} !== {4'b1100, 4'b0000, 4'd8, 2'b00})
        begin
            failures++;
            $display("FAIL full_count act=%b/%b/%0d/%b%b exp=1100/0000/8/00",
                     wptr_s, rptr, rd_count, empty, almost_empty);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if (((m_wr - m_rd + MOD) % MOD) < DEPTH && $urandom_range(0, 1) == 1)
                m_wr = (m_wr + 1) % MOD;
            rinc          = ($urandom_range(0, 99) < 55);
            underflow_clr = ($urandom_range(0, 9) == 0);
            #1;
            checks++;
            if (rd_en !== (rinc && !m_empty)) begin
                failures++;
                $display("FAIL rand_rd_en[%0d] act=%b exp=%b", i, rd_en, rinc && !m_empty);
            end
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL rand[%0d] act=%b exp=%b", i, dut_vec, exp_vec());
            end
        end
        rinc = 0; underflow_clr = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_wr = 6;
        tick();
        rinc = 1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (rd_addr !== 4'd3) begin
            failures++;
            $display("FAIL mid_pre act=%h exp=3", rd_addr);
        end
        rrst = 1;
        tick();
        checks++;
        if (dut_vec !== 15'b0000_0000_1_1_0000_0) begin
            failures++;
            $display("FAIL reset_mid act=%b exp=%b", dut_vec, 15'b0000_0000_1_1_0000_0);
        end
        rrst = 0; rinc = 0;
    endtask

    initial begin
        rrst = 1; rinc = 0; underflow_clr = 0; wptr_s = '0;
        m_rd = 0; m_wr = 0; m_cnt = 0; m_empty = 1; m_ae = 1; m_uf = 0;
        @(negedge rclk);
        test_reset();
        test_fill_view();
        test_drain();
        test_underflow();
        test_wrap();
        test_full_count();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
